// File: rtl/sel_enc_seq.sv
// sel_enc_seq: registered select-and-encode stage driving one-hot register-file enables in single-field or Rb/Rc/Ra sequence mode.
// Optional pending-destination hazard flag is built when SEL_ENC_SEQ_HAZARD_EN is defined.
module sel_enc_seq #(
  parameter int unsigned BITS        = 32,
  parameter int unsigned REGISTERS   = 16,
  parameter int unsigned OPCODE_BITS = 5,
  localparam int unsigned REGISTER_BITS = $clog2(REGISTERS)
) (
  input  logic                 clk,
  input  logic                 clr_n,
  input  logic                 ir_load,
  input  logic [BITS-1:0]      ir_in,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_seq,
  input  logic [1:0]           req_field,
  input  logic                 req_in,
  input  logic                 req_ba,
  output logic [REGISTERS-1:0] reg_in_ctrl,
  output logic [REGISTERS-1:0] reg_out_ctrl,
  output logic                 ba_zero,
  output logic [BITS-1:0]      c_sign_extended,
  output logic                 busy,
  output logic                 done
`ifdef SEL_ENC_SEQ_HAZARD_EN
  ,
  output logic                 hazard
`endif
);

  localparam int unsigned RA_MSB    = BITS - OPCODE_BITS - 1;
  localparam int unsigned RB_MSB    = RA_MSB - REGISTER_BITS;
  localparam int unsigned RC_MSB    = RB_MSB - REGISTER_BITS;
  localparam int unsigned IMM_BITS  = RC_MSB + 1;
  localparam int unsigned SEXT_BITS = BITS - IMM_BITS;
  localparam logic [1:0]  FIELD_NONE = 2'd3;

  typedef enum logic [2:0] {IDLE, SINGLE, SEQ_B, SEQ_C, SEQ_A} state_t;

  state_t                   state_q, state_d;
  logic [BITS-1:0]          ir_q, ir_d;
  logic [1:0]               field_q, field_d;
  logic                     in_q, in_d;
  logic                     ba_q, ba_d;
  logic                     accept_c;
  logic [REGISTER_BITS-1:0] ra_c, rb_c, rc_c, sel_c;
  logic                     sel_en_c, sel_out_c;
  logic [REGISTERS-1:0]     in_ctrl_d, out_ctrl_d;
  logic                     ba_zero_d, busy_d, done_d, ready_d;

  // Request attributes and IR as they will stand after this edge; IR is frozen while busy.
  assign accept_c = req_valid && req_ready;
  assign ir_d     = (ir_load && !busy) ? ir_in : ir_q;
  assign field_d  = accept_c ? req_field : field_q;
  assign in_d     = accept_c ? req_in    : in_q;
  assign ba_d     = accept_c ? req_ba    : ba_q;
  assign ra_c     = ir_d[RA_MSB -: REGISTER_BITS];
  assign rb_c     = ir_d[RB_MSB -: REGISTER_BITS];
  assign rc_c     = ir_d[RC_MSB -: REGISTER_BITS];

  // State register plus registered outputs computed for the upcoming state.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q         <= IDLE;
      ir_q            <= '0;
      field_q         <= '0;
      in_q            <= 1'b0;
      ba_q            <= 1'b0;
      reg_in_ctrl     <= '0;
      reg_out_ctrl    <= '0;
      ba_zero         <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      req_ready       <= 1'b0;
      c_sign_extended <= '0;
    end else begin
      state_q         <= state_d;
      ir_q            <= ir_d;
      field_q         <= field_d;
      in_q            <= in_d;
      ba_q            <= ba_d;
      reg_in_ctrl     <= in_ctrl_d;
      reg_out_ctrl    <= out_ctrl_d;
      ba_zero         <= ba_zero_d;
      busy            <= busy_d;
      done            <= done_d;
      req_ready       <= ready_d;
      c_sign_extended <= {{SEXT_BITS{ir_q[IMM_BITS-1]}}, ir_q[IMM_BITS-1:0]};
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = req_seq ? SEQ_B : SINGLE;
      SINGLE:  state_d = IDLE;
      SEQ_B:   state_d = SEQ_C;
      SEQ_C:   state_d = SEQ_A;
      SEQ_A:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output values for the upcoming state; an R0 out-enable under BAout becomes ba_zero.
  always_comb begin
    sel_c      = '0;
    sel_en_c   = 1'b0;
    sel_out_c  = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    ready_d    = (state_d == IDLE);
    in_ctrl_d  = '0;
    out_ctrl_d = '0;
    ba_zero_d  = 1'b0;
    case (state_d)
      SINGLE: begin
        done_d    = 1'b1;
        sel_en_c  = (field_d != FIELD_NONE);
        sel_out_c = !in_d;
        case (field_d)
          2'd0:    sel_c = ra_c;
          2'd1:    sel_c = rb_c;
          default: sel_c = rc_c;
        endcase
      end
      SEQ_B: begin
        busy_d    = 1'b1;
        sel_en_c  = 1'b1;
        sel_out_c = 1'b1;
        sel_c     = rb_c;
      end
      SEQ_C: begin
        busy_d    = 1'b1;
        sel_en_c  = 1'b1;
        sel_out_c = 1'b1;
        sel_c     = rc_c;
      end
      SEQ_A: begin
        busy_d    = 1'b1;
        done_d    = 1'b1;
        sel_en_c  = 1'b1;
        sel_c     = ra_c;
      end
      default: ;
    endcase
    if (sel_en_c) begin
      if (!sel_out_c)                  in_ctrl_d  = REGISTERS'(1) << sel_c;
      else if (ba_d && sel_c == '0)    ba_zero_d  = 1'b1;
      else                             out_ctrl_d = REGISTERS'(1) << sel_c;
    end
  end

`ifdef SEL_ENC_SEQ_HAZARD_EN
  logic [REGISTER_BITS-1:0] pend_q, single_reg_c;
  logic                     pend_valid_q, hazard_d;

  assign hazard_d = pend_valid_q && (state_d == SEQ_B || state_d == SEQ_C) && (sel_c == pend_q);

  // Register targeted by the single request currently in its SINGLE cycle.
  always_comb begin
    case (field_q)
      2'd0:    single_reg_c = ir_q[RA_MSB -: REGISTER_BITS];
      2'd1:    single_reg_c = ir_q[RB_MSB -: REGISTER_BITS];
      default: single_reg_c = ir_q[RC_MSB -: REGISTER_BITS];
    endcase
  end

  // Pending destination: set by a completed sequence, cleared by a single write to it.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      hazard       <= 1'b0;
    end else begin
      hazard <= hazard_d;
      if (state_q == SEQ_A) begin
        pend_q       <= ir_q[RA_MSB -: REGISTER_BITS];
        pend_valid_q <= 1'b1;
      end else if (state_q == SINGLE && in_q && field_q != FIELD_NONE && single_reg_c == pend_q) begin
        pend_valid_q <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sel_enc_seq.sv
// tb_sel_enc_seq: table vectors, directed corner sequences and randomized requests checked against a transaction-level model.
module tb_sel_enc_seq;

  localparam int unsigned NREG     = 16;
  localparam int unsigned RA_LSB   = 23;
  localparam int unsigned RB_LSB   = 19;
  localparam int unsigned RC_LSB   = 15;
  localparam int unsigned IMM_BITS = 19;

  logic        clk;
  logic        clr_n;
  logic        ir_load;
  logic [31:0] ir_in;
  logic        req_valid;
  logic        req_ready;
  logic        req_seq;
  logic [1:0]  req_field;
  logic        req_in;
  logic        req_ba;
  logic [15:0] reg_in_ctrl;
  logic [15:0] reg_out_ctrl;
  logic        ba_zero;
  logic [31:0] c_sign_extended;
  logic        busy;
  logic        done;
`ifdef SEL_ENC_SEQ_HAZARD_EN
  logic        hazard;
`endif

  sel_enc_seq dut (
    .clk             (clk),
    .clr_n           (clr_n),
    .ir_load         (ir_load),
    .ir_in           (ir_in),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_seq         (req_seq),
    .req_field       (req_field),
    .req_in          (req_in),
    .req_ba          (req_ba),
    .reg_in_ctrl     (reg_in_ctrl),
    .reg_out_ctrl    (reg_out_ctrl),
    .ba_zero         (ba_zero),
    .c_sign_extended (c_sign_extended),
    .busy            (busy),
    .done            (done)
`ifdef SEL_ENC_SEQ_HAZARD_EN
    ,
    .hazard          (hazard)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] in_c;
    logic [15:0] out_c;
    logic        baz;
    logic        busy;
    logic        done;
    logic        rdy;
    logic        hz;
  } exp_t;

  // Table entry: enables per step packed {step0, step1, step2}; baz bit 2 is step0.
  typedef struct {
    logic [31:0] ir;
    logic [31:0] imm;
    logic        s;
    logic [1:0]  f;
    logic        rin;
    logic        ba;
    logic [47:0] ins;
    logic [47:0] outs;
    logic [2:0]  bazs;
  } vec_t;

  vec_t        vecs[10];
  exp_t        expq[$];
  logic [31:0] ir_m;
  int unsigned pend_m;
  bit          pend_v;
  int          n_checks;
  int          n_errors;

  function automatic int unsigned fld(input logic [31:0] ir, input int unsigned lsb);
    return 32'((ir >> lsb) % NREG);
  endfunction

  function automatic logic [31:0] sext_m(input logic [31:0] ir);
    longint imm;
    imm = longint'(ir % 32'(1 << IMM_BITS));
    if (imm >= (longint'(1) << (IMM_BITS - 1))) imm = imm - (longint'(1) << IMM_BITS);
    return 32'(imm);
  endfunction

  function automatic exp_t out_step(input int unsigned r, input logic ba);
    exp_t e;
    e = '0;
    if (ba && r == 0) e.baz = 1'b1;
    else              e.out_c = 16'(1 << r);
    return e;
  endfunction

  function automatic exp_t idle_e();
    exp_t e;
    e = '0;
    e.rdy = 1'b1;
    return e;
  endfunction

  // Expected per-cycle outputs of one request, ending with the IDLE cycle after it.
  task automatic model_req(input logic s, input logic [1:0] f, input logic rin, input logic ba);
    int unsigned ra, rb, rc, sel;
    exp_t e;
    ra = fld(ir_m, RA_LSB);
    rb = fld(ir_m, RB_LSB);
    rc = fld(ir_m, RC_LSB);
    expq.delete();
    if (!s) begin
      e = '0;
      if (f != 2'd3) begin
        sel = (f == 2'd0) ? ra : (f == 2'd1) ? rb : rc;
        if (rin) begin
          e.in_c = 16'(1 << sel);
          if (pend_v && pend_m == sel) pend_v = 1'b0;
        end else begin
          e = out_step(sel, ba);
        end
      end
      e.done = 1'b1;
      expq.push_back(e);
    end else begin
      e = out_step(rb, ba);
      e.busy = 1'b1;
      e.hz = pend_v && (pend_m == rb);
      expq.push_back(e);
      e = out_step(rc, ba);
      e.busy = 1'b1;
      e.hz = pend_v && (pend_m == rc);
      expq.push_back(e);
      e = '0;
      e.in_c = 16'(1 << ra);
      e.busy = 1'b1;
      e.done = 1'b1;
      expq.push_back(e);
      pend_m = ra;
      pend_v = 1'b1;
    end
    expq.push_back(idle_e());
  endtask

  task automatic chk(input string nm, input exp_t e);
    n_checks++;
    if (reg_in_ctrl !== e.in_c || reg_out_ctrl !== e.out_c || ba_zero !== e.baz ||
        busy !== e.busy || done !== e.done || req_ready !== e.rdy) begin
      n_errors++;
      $display("FAIL %s: got in=%h out=%h baz=%b busy=%b done=%b rdy=%b, expected in=%h out=%h baz=%b busy=%b done=%b rdy=%b",
               nm, reg_in_ctrl, reg_out_ctrl, ba_zero, busy, done, req_ready,
               e.in_c, e.out_c, e.baz, e.busy, e.done, e.rdy);
    end
`ifdef SEL_ENC_SEQ_HAZARD_EN
    n_checks++;
    if (hazard !== e.hz) begin
      n_errors++;
      $display("FAIL %s_hazard: got %b expected %b", nm, hazard, e.hz);
    end
`endif
  endtask

  task automatic chk_sext(input string nm, input logic [31:0] exp_v);
    n_checks++;
    if (c_sign_extended !== exp_v) begin
      n_errors++;
      $display("FAIL %s_imm: got %h expected %h", nm, c_sign_extended, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input string nm);
    ir_load = 1'b0;
    tick();
    chk(nm, idle_e());
  endtask

  task automatic load_ir(input logic [31:0] v);
    ir_load = 1'b1;
    ir_in   = v;
    tick();
    ir_load = 1'b0;
    ir_in   = $urandom;
    ir_m    = v;
    chk("load", idle_e());
    tick();
    chk("load_wait", idle_e());
    chk_sext("load", sext_m(v));
  endtask

  // Drive one request from IDLE and check every cycle against expq; noise on inputs after acceptance.
  task automatic apply_req(input string nm, input logic s, input logic [1:0] f, input logic rin, input logic ba);
    req_valid = 1'b1;
    req_seq   = s;
    req_field = f;
    req_in    = rin;
    req_ba    = ba;
    tick();
    req_valid = 1'b0;
    req_seq   = 1'($urandom);
    req_field = 2'($urandom);
    req_in    = 1'($urandom);
    req_ba    = 1'($urandom);
    foreach (expq[i]) begin
      chk($sformatf("%s_step%0d", nm, i), expq[i]);
      if (i < expq.size() - 1) begin
        ir_in   = $urandom;
        ir_load = s && (i < 3) && ($urandom_range(1, 0) == 1);
        tick();
      end
    end
    ir_load = 1'b0;
    chk_sext(nm, sext_m(ir_m));
  endtask

  task automatic run_req(input string nm, input logic s, input logic [1:0] f, input logic rin, input logic ba);
    model_req(s, f, rin, ba);
    apply_req(nm, s, f, rin, ba);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int          steps;
    clr_n = 1'b0; ir_load = 1'b0; ir_in = '0; req_valid = 1'b0;
    req_seq = 1'b0; req_field = '0; req_in = 1'b0; req_ba = 1'b0;
    ir_m = '0; pend_m = 0; pend_v = 1'b0; n_checks = 0; n_errors = 0;

    vecs[0] = '{32'h192B8000, 32'h00038000, 1'b1, 2'd0, 1'b0, 1'b0,
                {16'h0000, 16'h0000, 16'h0004}, {16'h0020, 16'h0080, 16'h0000}, 3'b000};
    vecs[1] = '{32'h0007FFFF, 32'hFFFFFFFF, 1'b0, 2'd0, 1'b0, 1'b1,
                {16'h0000, 16'h0000, 16'h0000}, {16'h0000, 16'h0000, 16'h0000}, 3'b100};
    vecs[2] = '{32'h0007FFFF, 32'hFFFFFFFF, 1'b0, 2'd0, 1'b0, 1'b0,
                {16'h0000, 16'h0000, 16'h0000}, {16'h0001, 16'h0000, 16'h0000}, 3'b000};
    vecs[3] = '{32'h0007FFFF, 32'hFFFFFFFF, 1'b0, 2'd1, 1'b1, 1'b1,
                {16'h0001, 16'h0000, 16'h0000}, {16'h0000, 16'h0000, 16'h0000}, 3'b000};
    vecs[4] = '{32'h0007FFFF, 32'hFFFFFFFF, 1'b0, 2'd2, 1'b0, 1'b1,
                {16'h0000, 16'h0000, 16'h0000}, {16'h8000, 16'h0000, 16'h0000}, 3'b000};
    vecs[5] = '{32'h0007FFFF, 32'hFFFFFFFF, 1'b0, 2'd3, 1'b1, 1'b1,
                {16'h0000, 16'h0000, 16'h0000}, {16'h0000, 16'h0000, 16'h0000}, 3'b000};
    vecs[6] = '{32'h192B8000, 32'h00038000, 1'b1, 2'd0, 1'b0, 1'b1,
                {16'h0000, 16'h0000, 16'h0004}, {16'h0020, 16'h0080, 16'h0000}, 3'b000};
    vecs[7] = '{32'h00000000, 32'h00000000, 1'b1, 2'd0, 1'b0, 1'b1,
                {16'h0000, 16'h0000, 16'h0001}, {16'h0000, 16'h0000, 16'h0000}, 3'b110};
    vecs[8] = '{32'h00000000, 32'h00000000, 1'b1, 2'd0, 1'b0, 1'b0,
                {16'h0000, 16'h0000, 16'h0001}, {16'h0001, 16'h0001, 16'h0000}, 3'b000};
    vecs[9] = '{32'h00000000, 32'h00000000, 1'b0, 2'd3, 1'b0, 1'b1,
                {16'h0000, 16'h0000, 16'h0000}, {16'h0000, 16'h0000, 16'h0000}, 3'b000};

    // Reset and release.
    repeat (2) begin
      tick();
      chk("reset", '0);
    end
    chk_sext("reset", 32'h0);
    clr_n = 1'b1;
    tick();
    chk("reset_release", idle_e());

    // Table vectors.
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].ir != ir_m) load_ir(vecs[i].ir);
      chk_sext($sformatf("vec%0d", i), vecs[i].imm);
      model_req(vecs[i].s, vecs[i].f, vecs[i].rin, vecs[i].ba);
      steps = vecs[i].s ? 3 : 1;
      for (int k = 0; k < steps; k++) begin
        expq[k].in_c  = vecs[i].ins[47 - 16*k -: 16];
        expq[k].out_c = vecs[i].outs[47 - 16*k -: 16];
        expq[k].baz   = vecs[i].bazs[2 - k];
      end
      apply_req($sformatf("vec%0d", i), vecs[i].s, vecs[i].f, vecs[i].rin, vecs[i].ba);
    end

    // Reset held two cycles in the middle of SEQ_C aborts with no done pulse.
    load_ir(32'h192B8000);
    model_req(1'b1, 2'd0, 1'b0, 1'b0);
    req_valid = 1'b1; req_seq = 1'b1; req_ba = 1'b0;
    tick();
    req_valid = 1'b0;
    chk("abort_seqb", expq[0]);
    tick();
    chk("abort_seqc", expq[1]);
    clr_n = 1'b0;
    tick();
    chk("abort_rst0", '0);
    tick();
    chk("abort_rst1", '0);
    clr_n = 1'b1;
    ir_m = '0;
    pend_v = 1'b0;
    tick();
    chk("abort_release", idle_e());
    tick();
    chk("abort_idle", idle_e());
    chk_sext("abort", 32'h0);

    // ir_load during SEQ_C is ignored for the remaining steps and after done.
    load_ir(32'h192B8000);
    model_req(1'b1, 2'd0, 1'b0, 1'b0);
    req_valid = 1'b1; req_seq = 1'b1; req_ba = 1'b0;
    tick();
    req_valid = 1'b0;
    chk("irhold_b", expq[0]);
    tick();
    chk("irhold_c", expq[1]);
    ir_load = 1'b1;
    ir_in   = 32'hFFFFFFFF;
    tick();
    chk("irhold_a", expq[2]);
    n_checks++;
    if (reg_in_ctrl !== 16'h0004) begin
      n_errors++;
      $display("FAIL irhold_ra: got in=%h expected 0004", reg_in_ctrl);
    end
    tick();
    ir_load = 1'b0;
    chk("irhold_idle", expq[3]);
    tick();
    chk_sext("irhold", 32'h00038000);
    run_req("irhold_single", 1'b0, 2'd0, 1'b1, 1'b0);

    // Pending-destination sequences (hazard compared only when the feature is built).
    run_req("haz_hit", 1'b1, 2'd0, 1'b0, 1'b0);
    load_ir(32'h02118000);
    run_req("haz_hit2", 1'b1, 2'd0, 1'b0, 1'b0);
    run_req("haz_single_r2", 1'b0, 2'd1, 1'b1, 1'b0);
    run_req("haz_repeat", 1'b1, 2'd0, 1'b0, 1'b0);
    load_ir(32'h192B8000);
    run_req("haz_set2", 1'b1, 2'd0, 1'b0, 1'b0);
    run_req("haz_clear2", 1'b0, 2'd0, 1'b1, 1'b0);
    load_ir(32'h02118000);
    run_req("haz_cleared", 1'b1, 2'd0, 1'b0, 1'b0);

    // Randomized requests, gaps and IR loads.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(2, 0) == 0) begin
        v = $urandom;
        if ($urandom_range(1, 0) == 1) begin
          v[26:23] = 4'($urandom_range(3, 0));
          v[22:19] = 4'($urandom_range(3, 0));
          v[18:15] = 4'($urandom_range(3, 0));
        end
        load_ir(v);
      end
      repeat ($urandom_range(2, 0)) idle_cycle("gap");
      run_req($sformatf("rnd%0d", n), 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
